// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch/decode stage and its
// field decoder: instruction field positions, the legal-opcode limit
// and the fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned OPC_HI  = 15;
  localparam int unsigned OPC_LO  = 12;
  localparam int unsigned MODE_HI = 11;
  localparam int unsigned MODE_LO = 8;
  localparam int unsigned IMM_HI  = 7;
  localparam int unsigned IMM_LO  = 0;

  // Opcodes above this value are illegal.
  localparam logic [3:0] OPC_MAX = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field splitter.
// Ports:
//   instr  - instruction word (fixed 16-bit layout)
//   opcode - instr[15:12]
//   mode   - instr[11:8]
//   imm    - instr[7:0]
//   legal  - opcode is within the legal range
module instr_field_decode
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mode,
  output logic [7:0]         imm,
  output logic               legal
);

  always_comb begin
    opcode = instr[OPC_HI:OPC_LO];
    mode   = instr[MODE_HI:MODE_LO];
    imm    = instr[IMM_HI:IMM_LO];
    legal  = (instr[OPC_HI:OPC_LO] <= OPC_MAX);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/decode stage. Accepts an address from the program
// counter, issues one ROM read (1-cycle latency), decodes the returned
// word and holds it on a valid/ready output until the ALU takes it.
// Illegal opcodes raise a one-cycle illegal pulse and are dropped.
// Ports:
//   count      - clock, rising edge
//   reset      - asynchronous active-low reset
//   addr_in    - instruction address, with addr_valid / addr_ready
//   mem_rd     - ROM read strobe (high in READ only)
//   mem_addr   - ROM address (always the address register)
//   mem_rdata  - ROM data, valid the cycle after mem_rd
//   op_valid   - decoded operation valid, with op_ready
//   op_code, op_mode, op_imm, op_addr - decoded operation fields
//   illegal    - one-cycle pulse for an illegal fetched opcode
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               count,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               addr_valid,
  output logic               addr_ready,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [3:0]         op_code,
  output logic [3:0]         op_mode,
  output logic [7:0]         op_imm,
  output logic [ADDR_W-1:0]  op_addr,
  output logic               illegal
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op_code_q, op_code_d;
  logic [3:0]        op_mode_q, op_mode_d;
  logic [7:0]        op_imm_q, op_imm_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic              illegal_q, illegal_d;

  logic [3:0] dec_opcode;
  logic [3:0] dec_mode;
  logic [7:0] dec_imm;
  logic       dec_legal;

  instr_field_decode #(
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr  (mem_rdata),
    .opcode (dec_opcode),
    .mode   (dec_mode),
    .imm    (dec_imm),
    .legal  (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_code_d = op_code_q;
    op_mode_d = op_mode_q;
    op_imm_d  = op_imm_q;
    op_addr_d = op_addr_q;
    illegal_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (addr_valid) begin
          addr_d  = addr_in;
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (dec_legal) begin
          op_code_d = dec_opcode;
          op_mode_d = dec_mode;
          op_imm_d  = dec_imm;
          op_addr_d = addr_q;
          state_d   = VALID;
        end else begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end
      end
      VALID: begin
        // Handshake and next accept share an edge; addr_valid is
        // ignored while the ALU stalls.
        if (op_ready) begin
          if (addr_valid) begin
            addr_d  = addr_in;
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge count or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      op_code_q <= '0;
      op_mode_q <= '0;
      op_imm_q  <= '0;
      op_addr_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_code_q <= op_code_d;
      op_mode_q <= op_mode_d;
      op_imm_q  <= op_imm_d;
      op_addr_q <= op_addr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    addr_ready = (state_q == IDLE) || ((state_q == VALID) && op_ready);
    mem_rd     = (state_q == READ);
    mem_addr   = addr_q;
    op_valid   = (state_q == VALID);
    op_code    = op_code_q;
    op_mode    = op_mode_q;
    op_imm     = op_imm_q;
    op_addr    = op_addr_q;
    illegal    = illegal_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        count = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  addr_in = '0;
  logic        addr_valid = 1'b0;
  logic        addr_ready;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [3:0]  op_code;
  logic [3:0]  op_mode;
  logic [7:0]  op_imm;
  logic [3:0]  op_addr;
  logic        illegal;

  always #5 count = ~count;

  instr_fetch #(
    .ADDR_W  (4),
    .INSTR_W (16)
  ) dut (
    .count      (count),
    .reset      (reset),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_mode    (op_mode),
    .op_imm     (op_imm),
    .op_addr    (op_addr),
    .illegal    (illegal)
  );

  // ROM model: 1-cycle read latency, data held between reads.
  logic [15:0] rom [16];
  always @(posedge count) if (mem_rd) mem_rdata <= rom[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       ill;
    logic [3:0] code;
    logic [3:0] mode;
    logic [7:0] imm;
    logic [3:0] addr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_hs = -1;
  logic stream = 1'b0;
  logic prev_ov = 1'b0;

  always @(posedge count) cyc++;

  // Monitor: pops on output events first, then pushes newly accepted addresses.
  always @(negedge count) begin
    exp_t e;
    logic [15:0] w;
    if (reset) begin
      if (op_valid && !prev_ov) begin
        check_val("op_pending", sb.size() > 0, 1);
        if (sb.size() > 0) check_val("latency", cyc - sb[0].cyc, 3);
      end
      if (op_valid && op_ready) begin
        check_val("op_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("op_not_illegal", {31'd0, e.ill}, 0);
          check_val("op_code", op_code, e.code);
          check_val("op_mode", op_mode, e.mode);
          check_val("op_imm",  op_imm,  e.imm);
          check_val("op_addr", op_addr, e.addr);
        end
        if (stream && last_hs >= 0) check_val("throughput", cyc - last_hs, 3);
        last_hs = cyc;
      end
      if (illegal) begin
        check_val("ill_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("ill_flag", {31'd0, e.ill}, 1);
          check_val("ill_latency", cyc - e.cyc, 3);
        end
        check_val("ill_no_valid", op_valid, 0);
      end
      if (addr_valid && addr_ready) begin
        w      = rom[addr_in];
        e.code = w[15:12];
        e.mode = w[11:8];
        e.imm  = w[7:0];
        e.addr = addr_in;
        e.ill  = (w[15:12] > 4'hB);
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
    prev_ov <= op_valid;
  end

  task automatic tick();
    @(posedge count);
    #1;
  endtask

  task automatic wait_op(input int max_cyc);
    int n = 0;
    while (!op_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check_val("op_valid_timeout", op_valid, 1);
  endtask

  task automatic fetch_one(input logic [3:0] a);
    addr_in    = a;
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
  endtask

  logic [3:0]  s_code, s_mode, s_addr;
  logic [7:0]  s_imm;
  int          ill_cnt;
  logic        ov_seen;
  logic [3:0]  stream_addr [5];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000 | 16'(i);
    rom[0]  = 16'h0111;
    rom[3]  = 16'h2A5C;
    rom[4]  = 16'h4B22;
    rom[5]  = 16'h1234;
    rom[7]  = 16'hE011;
    rom[8]  = 16'hB0FF;
    rom[9]  = 16'h7001;
    rom[12] = 16'h5C33;

    // Reset state
    #1;
    check_val("rst_op_valid", op_valid, 0);
    check_val("rst_mem_rd",   mem_rd, 0);
    check_val("rst_illegal",  illegal, 0);
    @(negedge count);
    reset = 1'b1;
    #1;
    check_val("rst_addr_ready", addr_ready, 1);

    // Reset while in WAIT; ROM response must be dropped
    tick();
    fetch_one(4'h5);
    tick();
    reset = 1'b0;
    sb.delete();
    #1;
    check_val("mid_op_valid", op_valid, 0);
    check_val("mid_op_code",  op_code, 0);
    check_val("mid_op_mode",  op_mode, 0);
    check_val("mid_op_imm",   op_imm, 0);
    check_val("mid_op_addr",  op_addr, 0);
    check_val("mid_mem_rd",   mem_rd, 0);
    check_val("mid_mem_addr", mem_addr, 0);
    check_val("mid_illegal",  illegal, 0);
    tick();
    reset = 1'b1;
    #1;
    check_val("mid_rel_ready", addr_ready, 1);
    repeat (3) tick();
    check_val("mid_no_valid", op_valid, 0);

    // Single fetch
    op_ready = 1'b1;
    fetch_one(4'h3);
    check_val("single_mem_rd",   mem_rd, 1);
    check_val("single_mem_addr", mem_addr, 4'h3);
    check_val("single_ready_rd", addr_ready, 0);
    tick();
    check_val("single_rd_pulse", mem_rd, 0);
    check_val("single_ready_wt", addr_ready, 0);
    tick();
    check_val("single_valid", op_valid, 1);
    tick();

    // Backpressure
    op_ready = 1'b0;
    fetch_one(4'h9);
    wait_op(6);
    s_code = op_code; s_mode = op_mode; s_imm = op_imm; s_addr = op_addr;
    addr_in    = 4'hC;
    addr_valid = 1'b1;
    repeat (5) begin
      tick();
      check_val("bp_valid", op_valid, 1);
      check_val("bp_ready", addr_ready, 0);
      check_val("bp_stable", {op_code, op_mode, op_imm, op_addr}, {s_code, s_mode, s_imm, s_addr});
      check_val("bp_no_rd", mem_rd, 0);
    end
    op_ready = 1'b1;
    tick();
    addr_valid = 1'b0;
    check_val("bp_next_rd",   mem_rd, 1);
    check_val("bp_next_addr", mem_addr, 4'hC);
    wait_op(6);
    tick();

    // Illegal opcode, then a normal fetch
    fetch_one(4'h7);
    ill_cnt = 0;
    ov_seen = 1'b0;
    repeat (5) begin
      tick();
      ill_cnt += int'(illegal);
      ov_seen |= op_valid;
    end
    check_val("ill_pulses", ill_cnt, 1);
    check_val("ill_ov_seen", ov_seen, 0);
    check_val("ill_idle_ready", addr_ready, 1);
    fetch_one(4'h3);
    wait_op(6);
    tick();
    repeat (2) tick();

    // Back-to-back stream
    stream_addr[0] = 4'h0; stream_addr[1] = 4'h4; stream_addr[2] = 4'h8;
    stream_addr[3] = 4'hC; stream_addr[4] = 4'h0;
    last_hs = -1;
    stream  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int n;
      addr_in    = stream_addr[i];
      addr_valid = 1'b1;
      n = 0;
      @(negedge count);
      while (!addr_ready && n < 10) begin
        @(negedge count);
        n++;
      end
      check_val("stream_accept_timeout", addr_ready, 1);
      tick();
    end
    addr_valid = 1'b0;
    wait_op(6);
    repeat (3) tick();
    stream = 1'b0;

    check_val("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch/decode stage that consumes the instruction addresses produced by the program counter and turns them into decoded operations for the 8-bit ALU. Each accepted address is issued as a single read to the instruction ROM (fixed 1-cycle read latency). The returned 16-bit word is split into opcode, mode and immediate fields and held on a valid/ready output until the ALU takes it. Illegal opcodes are flagged and never forwarded.

## Interface
- ADDR_W, 4, instruction address width; must equal the program counter width
- INSTR_W, 16, instruction word width; fixed layout, other values unsupported
- count  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- addr_in  in  ADDR_W  instruction address from the program counter
- addr_valid  in  1  addr_in is valid
- addr_ready  out  1  block accepts addr_in this cycle
- mem_rd  out  1  ROM read strobe, one cycle per fetch
- mem_addr  out  ADDR_W  ROM read address
- mem_rdata  in  INSTR_W  ROM data, valid the cycle after mem_rd
- op_valid  out  1  decoded operation valid
- op_ready  in  1  ALU accepts the operation
- op_code  out  4  instr[15:12]
- op_mode  out  4  instr[11:8]
- op_imm  out  8  instr[7:0]
- op_addr  out  ADDR_W  address the operation was fetched from
- illegal  out  1  one-cycle pulse: fetched opcode is illegal

## Operation
- FSM states: IDLE, READ, WAIT, VALID.
- IDLE: addr_ready=1. On addr_valid: latch addr_in into the address register, go to READ.
- READ: mem_rd=1, mem_addr = latched address. Go to WAIT unconditionally.
- WAIT: sample mem_rdata at the closing edge.
  - Legal opcode (0x0–0xB): load op_code/op_mode/op_imm/op_addr, go to VALID.
  - Illegal opcode (0xC–0xF): output registers unchanged, illegal=1 for the next cycle, go to IDLE.
- VALID: op_valid=1, and all op_* outputs are held stable until the handshake.
  - addr_ready = op_ready.
  - op_ready & addr_valid: latch the new address, go to READ (back-to-back fetch).
  - op_ready & !addr_valid: go to IDLE.
  - !op_ready: stay in VALID. addr_valid is ignored.
- mem_addr is driven from the address register in every state. mem_rd is 1 only in READ.
- addr_ready is 0 in READ and WAIT.
- Reset (asynchronous, any state): state=IDLE. op_valid, op_code, op_mode, op_imm, op_addr, mem_rd, mem_addr, illegal and the address register all go to 0. Any fetch in flight is dropped; a ROM response arriving after reset is ignored.
- After reset release: addr_ready=1 in the first cycle.

## Timing
- Address accepted at edge E0:
  - mem_rd high during cycle E0–E1.
  - mem_rdata sampled at E2.
  - op_valid high from E2.
- Latency: 2 cycles from address acceptance to op_valid.
- Illegal fetch: illegal high for the single cycle E2–E3; op_valid stays 0.
- Throughput: one operation per 3 cycles with op_ready held high and addresses always available. Output handshake and the next address accept happen on the same edge.
- No combinational path from addr_valid or mem_rdata to any output. addr_ready depends combinationally on op_ready in VALID only.

## Structure
- Package fetch_pkg holds:
  - field positions: OPC_HI=15, OPC_LO=12, MODE_HI=11, MODE_LO=8, IMM_HI=7, IMM_LO=0;
  - the legal-opcode limit OPC_MAX=4'hB;
  - the 2-bit state encoding: IDLE=0, READ=1, WAIT=2, VALID=3.
- One combinational sub-module, instr_field_decode: INSTR_W word in, opcode/mode/imm/legal out. It is shared with the future disassembler monitor.
- The FSM and output registers live in instr_fetch.

## Test plan
- Reset mid-fetch: assert reset while in WAIT, ROM returns 0x1234 next cycle -> all outputs 0, state IDLE, no op_valid, addr_ready=1 after release.
- Single fetch: addr_in=0x3, ROM[3]=0x2A5C, op_ready=1 -> mem_rd pulses with mem_addr=0x3; two cycles after accept op_valid=1 with op_code=0x2, op_mode=0xA, op_imm=0x5C, op_addr=0x3.
- Backpressure: op_ready=0 for 5 cycles after op_valid -> outputs stable, addr_ready=0, new addr_valid ignored; op_ready=1 -> handshake, then the pending address is accepted on the same edge.
- Illegal opcode: ROM[7]=0xE011 -> illegal high exactly one cycle, op_valid never asserts, block returns to IDLE and fetches the next address normally.
- Back-to-back stream: addresses 0x0,0x4,0x8,0xC (PC offset 4, wrapping to 0x0), op_ready tied 1 -> operations emerge in order with matching op_addr, one every 3 cycles, no drops or duplicates.
